// File: rtl/stopwatch_ctrl_if.sv
// stopwatch_ctrl_if
//   Groups the stopwatch controller's control inputs and display/status
//   outputs into one bundle.
//   master : button/preset source (drives buttons and preset, observes status)
//   slave  : stopwatch_ctrl (consumes buttons and preset, drives status)
//   Signals:
//     btn_start_stop, btn_lap_clear : one-cycle debounced button pulses
//     test_value[31:0], latch_test_value : BCD preset and its load strobe
//     elapsed[31:0], display[31:0]  : live count and displayed value (BCD)
//     running, lap_active, load_error : status flags
interface stopwatch_ctrl_if;
    logic        btn_start_stop;
    logic        btn_lap_clear;
    logic [31:0] test_value;
    logic        latch_test_value;
    logic [31:0] elapsed;
    logic [31:0] display;
    logic        running;
    logic        lap_active;
    logic        load_error;

    modport master (
        output btn_start_stop, btn_lap_clear, test_value, latch_test_value,
        input  elapsed, display, running, lap_active, load_error
    );

    modport slave (
        input  btn_start_stop, btn_lap_clear, test_value, latch_test_value,
        output elapsed, display, running, lap_active, load_error
    );
endinterface

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl
//   Start/stop/lap/clear sequencer owning the MMMM:SS.hh BCD elapsed counter.
//   A prescaler divides clk down to TICK_HZ; each tick ripples the BCD count.
//   Preset loads are validated (BCD digits, seconds tens <= 5) before use.
//   Optional feature macro: STOPWATCH_LAP_EN (LAP state + lap register).
//   Ports:
//     clk   : sole clock
//     reset : asynchronous active-high reset
//     bus   : stopwatch_ctrl_if.slave (buttons, preset, elapsed/display/status)
//   All outputs come from registers (state, counters, flags).
module stopwatch_ctrl #(
    parameter int CLK_FREQ = 100_000_000,
    parameter int TICK_HZ  = 100
) (
    input  logic              clk,
    input  logic              reset,
    stopwatch_ctrl_if.slave   bus
);
    localparam int DIV = CLK_FREQ / TICK_HZ;
    localparam int PW  = $clog2(DIV);
    localparam logic [PW-1:0] PMAX = PW'(DIV - 1);

`ifdef STOPWATCH_LAP_EN
    typedef enum logic [1:0] {ST_STOPPED, ST_RUN, ST_LAP} state_t;
`else
    typedef enum logic [1:0] {ST_STOPPED, ST_RUN} state_t;
`endif

    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [31:0]   elapsed_q, elapsed_d, elapsed_inc;
    logic          lderr_q, lderr_d;
    logic          tick, preset_ok;
`ifdef STOPWATCH_LAP_EN
    logic [31:0]   lap_q, lap_d;
`endif

    // Ripple increment over eight BCD digits; digit 3 (seconds tens) wraps at 5.
    function automatic logic [31:0] bcd_inc(input logic [31:0] v);
        logic [31:0] r;
        logic        c;
        logic [3:0]  lim;
        r = v;
        c = 1'b1;
        for (int i = 0; i < 8; i++) begin
            lim = (i == 3) ? 4'd5 : 4'd9;
            if (c) begin
                if (v[i*4 +: 4] >= lim) begin
                    r[i*4 +: 4] = 4'd0;
                end else begin
                    r[i*4 +: 4] = v[i*4 +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
        end
        return r;
    endfunction

    always_comb begin
        preset_ok = (bus.test_value[15:12] <= 4'd5);
        for (int i = 0; i < 8; i++)
            if (bus.test_value[i*4 +: 4] > 4'd9) preset_ok = 1'b0;
    end

    // Tick is a compare on the registered prescaler, so it is not tied to any input.
    assign tick        = (state_q != ST_STOPPED) && (presc_q == PMAX);
    assign elapsed_inc = tick ? bcd_inc(elapsed_q) : elapsed_q;

    always_comb begin
        state_d   = state_q;
        elapsed_d = elapsed_inc;
        lderr_d   = 1'b0;
        if (state_q == ST_STOPPED || tick) presc_d = '0;
        else                                presc_d = presc_q + 1'b1;
`ifdef STOPWATCH_LAP_EN
        lap_d = lap_q;
`endif
        if (bus.latch_test_value) begin
            // Load cycle swallows buttons, whether or not the preset is accepted.
            if (preset_ok) begin
                elapsed_d = bus.test_value;
                state_d   = ST_STOPPED;
                presc_d   = '0;
`ifdef STOPWATCH_LAP_EN
                lap_d     = '0;
`endif
            end else begin
                lderr_d = 1'b1;
            end
        end else begin
            unique case (state_q)
                ST_STOPPED: begin
                    if (bus.btn_start_stop)     state_d   = ST_RUN;
                    else if (bus.btn_lap_clear) elapsed_d = '0;
                end
                ST_RUN: begin
                    if (bus.btn_start_stop) begin
                        state_d = ST_STOPPED;
                        presc_d = '0;
                    end
`ifdef STOPWATCH_LAP_EN
                    else if (bus.btn_lap_clear) begin
                        state_d = ST_LAP;
                        lap_d   = elapsed_inc;
                    end
`endif
                end
`ifdef STOPWATCH_LAP_EN
                ST_LAP: begin
                    if (bus.btn_start_stop) begin
                        state_d = ST_STOPPED;
                        presc_d = '0;
                    end else if (bus.btn_lap_clear) begin
                        state_d = ST_RUN;
                    end
                end
`endif
                default: state_d = ST_STOPPED;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_STOPPED;
            presc_q   <= '0;
            elapsed_q <= '0;
            lderr_q   <= 1'b0;
`ifdef STOPWATCH_LAP_EN
            lap_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            elapsed_q <= elapsed_d;
            lderr_q   <= lderr_d;
`ifdef STOPWATCH_LAP_EN
            lap_q     <= lap_d;
`endif
        end
    end

    assign bus.elapsed    = elapsed_q;
    assign bus.running    = (state_q != ST_STOPPED);
    assign bus.load_error = lderr_q;
`ifdef STOPWATCH_LAP_EN
    assign bus.lap_active = (state_q == ST_LAP);
    assign bus.display    = (state_q == ST_LAP) ? lap_q : elapsed_q;
`else
    assign bus.lap_active = 1'b0;
    assign bus.display    = elapsed_q;
`endif
endmodule
